btn_press_classifier: RTL and testbench

Consumes the one-cycle press pulse from the button edge detector, together with the debounced button level. It classifies each gesture as a single press, double press or long press, and emits one registered one-cycle pulse per gesture. It sits between the button front-end and the mode/control FSMs, so those FSMs never count cycles themselves.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/press_timer.sv | 29 ++
 rtl/btn_press_classifier.sv | 103 ++++++++++
 tb/tb_btn_press_classifier.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button front-end consumers: gesture FSM encoding
// and default timing constants.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    WAIT2     = 3'd2,
    HELD2     = 3'd3,
    LONG_WAIT = 3'd4
  } btn_state_e;

  // 1 s hold / 250 ms double-press window at 100 MHz.
  localparam int BTN_LONG_HOLD = 100_000_000;
  localparam int BTN_DBL_WIN   = 25_000_000;
  localparam int BTN_CNT_W     = 27;

  function automatic logic gesture_active(btn_state_e s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/press_timer.sv
// Shared gesture timer: synchronous clear, count enable, and a compare
// against a limit supplied at run time by the FSM.
module press_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt_reg;

  // Saturates instead of wrapping; clear has priority over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign at_limit = (cnt_reg == limit);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies button gestures into single, double and long presses and emits
// one registered one-cycle pulse per completed gesture.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_HOLD = BTN_LONG_HOLD,
  parameter int DBL_WIN   = BTN_DBL_WIN,
  parameter int CNT_W     = BTN_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  input  logic level,
  output logic single_p,
  output logic double_p,
  output logic long_p,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_HOLD - 1);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_WIN - 1);

  btn_state_e       state_reg, state_next;
  logic             tmr_clr, tmr_en, tmr_at_limit;
  logic [CNT_W-1:0] tmr_limit;
  logic             single_next, double_next, long_next, busy_next;
  logic             single_reg, double_reg, long_reg, busy_reg;

  assign tmr_limit = (state_reg == WAIT2) ? DBL_LIM : LONG_LIM;

  press_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .limit   (tmr_limit),
    .at_limit(tmr_at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Release beats the long threshold, and a press beats the double-press timeout.
  always_comb begin
    state_next = state_reg;
    tmr_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press) state_next = HELD1;
      end
      HELD1: begin
        if (!level)            state_next = WAIT2;
        else if (tmr_at_limit) state_next = LONG_WAIT;
        else                   tmr_en     = 1'b1;
      end
      WAIT2: begin
        if (press)             state_next = HELD2;
        else if (tmr_at_limit) state_next = IDLE;
        else                   tmr_en     = 1'b1;
      end
      HELD2, LONG_WAIT: begin
        if (!level) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    tmr_clr = (state_next != state_reg);
  end

  // busy spans the gesture states plus the first IDLE cycle after a gesture ends.
  always_comb begin
    single_next = (state_reg == WAIT2) && !press && tmr_at_limit;
    double_next = (state_reg == WAIT2) && press;
    long_next   = (state_reg == HELD1) && level && tmr_at_limit;
    busy_next   = gesture_active(state_reg) || gesture_active(state_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      single_reg <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      single_reg <= single_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      busy_reg   <= busy_next;
    end
  end

  assign single_p = single_reg;
  assign double_p = double_reg;
  assign long_p   = long_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Self-checking bench for btn_press_classifier with LONG_HOLD=8, DBL_WIN=6, CNT_W=4.
module tb_btn_press_classifier;

  logic clk, rst, press, level;
  logic single_p, double_p, long_p, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic s;
    logic d;
    logic l;
    logic b;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] press_m;
    logic [31:0] level_m;
    int          single_c;
    int          double_c;
    int          long_c;
    int          busy_last;
    int          len;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  btn_press_classifier #(
    .LONG_HOLD(8),
    .DBL_WIN  (6),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .press   (press),
    .level   (level),
    .single_p(single_p),
    .double_p(double_p),
    .long_p  (long_p),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rng(int lo, int hi);
    logic [31:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(string n, logic [31:0] p, logic [31:0] l,
                              int s, int d, int lg, int bl);
    vec_t v;
    v.name      = n;
    v.press_m   = p;
    v.level_m   = l;
    v.single_c  = s;
    v.double_c  = d;
    v.long_c    = lg;
    v.busy_last = bl;
    v.len       = bl + 3;
    return v;
  endfunction

  task automatic check(string name, int cyc, logic got, logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, required %b", name, cyc, got, req);
    end
  endtask

  task automatic check_all(string name, int cyc, exp_t e);
    check({name, ".single_p"}, cyc, single_p, e.s);
    check({name, ".double_p"}, cyc, double_p, e.d);
    check({name, ".long_p"},   cyc, long_p,   e.l);
    check({name, ".busy"},     cyc, busy,     e.b);
  endtask

  task automatic run_vec(vec_t v);
    exp_t e, got_e;
    for (int c = 0; c < v.len; c++) begin
      @(posedge clk);
      #1;
      press = v.press_m[c];
      level = v.level_m[c];
      e.s = (c == v.single_c);
      e.d = (c == v.double_c);
      e.l = (c == v.long_c);
      e.b = (c >= 1) && (c <= v.busy_last);
      sb.push_back(e);
      @(negedge clk);
      got_e = sb.pop_front();
      check_all(v.name, c, got_e);
    end
    press = 1'b0;
    level = 1'b0;
    $display("vec %-14s : %0d cycles, checks so far %0d, errors %0d",
             v.name, v.len, checks, errors);
  endtask

  initial begin
    exp_t zero;
    zero  = '0;
    rst   = 1'b0;
    press = 1'b0;
    level = 1'b0;

    // cycle numbers relative to the first press
    vecs[0] = mk("single",       32'h1,            rng(0, 2),                 10, -1, -1, 10);
    vecs[1] = mk("double",       rng(0,0)|rng(5,5), rng(0, 2) | rng(5, 6),    -1,  6, -1,  8);
    vecs[2] = mk("long",         32'h1,            rng(0, 11),                -1, -1,  9, 13);
    vecs[3] = mk("press_at_tmo", rng(0,0)|rng(9,9), rng(0, 2) | rng(9, 10),   -1, 10, -1, 12);
    vecs[4] = mk("release_at_8", 32'h1,            rng(0, 7),                 15, -1, -1, 15);
    vecs[5] = mk("ign_held1",    rng(0, 2),        rng(0, 2),                 10, -1, -1, 10);
    vecs[6] = mk("ign_held2",    rng(0,0)|rng(5,7), rng(0, 2) | rng(5, 6),    -1,  6, -1,  8);
    vecs[7] = mk("ign_longwait", rng(0,0)|rng(3,3)|rng(10,11), rng(0, 11),    -1, -1,  9, 13);
    vecs[8] = mk("dbl_no_long",  rng(0,0)|rng(5,5), rng(0, 2) | rng(5, 20),   -1,  6, -1, 22);

    // reset state, with inputs toggling while held in reset
    repeat (2) @(posedge clk);
    #1 press = 1'b1; level = 1'b1;
    @(negedge clk);
    check_all("reset", 0, zero);
    #1 press = 1'b0; level = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // asynchronous reset in the middle of a gesture
    @(posedge clk);
    #1 press = 1'b1; level = 1'b1;
    @(posedge clk);
    #1 press = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mid.busy_before", 3, busy, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_all("rst_mid.immediate", 4, zero);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 level = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all("rst_mid.quiet", 7 + c, zero);
    end
    $display("vec %-14s : reset mid-gesture, checks so far %0d, errors %0d",
             "rst_mid", checks, errors);

    run_vec(vecs[0]);
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
